// File: rtl/bank_register_pkg.sv
// Shared constants for the MIPS general-purpose register bank.
package bank_register_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_REG_DEF  = 5;
  localparam int unsigned N_REGS_DEF  = 2 ** NB_REG_DEF;
  localparam int unsigned REG_ZERO    = 0;

endpackage

// File: rtl/bank_register_read_port.sv
// One combinational read port: array select, r0 forced to zero, write-through bypass.
module bank_register_read_port
  import bank_register_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_REG  = NB_REG_DEF
) (
  input  logic [NB_DATA-1:0] regs [2**NB_REG],
  input  logic [NB_REG-1:0]  addr,
  input  logic               wr_en,
  input  logic [NB_REG-1:0]  addr_w,
  input  logic [NB_DATA-1:0] data_w,
  output logic [NB_DATA-1:0] data
);

  // addr != 0 in the bypass branch already implies addr_w != 0
  always_comb begin
    data = regs[addr];
    if (addr == NB_REG'(REG_ZERO)) begin
      data = '0;
    end else if (wr_en && (addr == addr_w)) begin
      data = data_w;
    end
  end

endmodule

// File: rtl/bank_register.sv
// MIPS register file: 2**NB_REG x NB_DATA flops, two combinational read ports, one write port.
module bank_register
  import bank_register_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_REG  = NB_REG_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rw,
  input  logic [NB_REG-1:0]  i_addr_ra,
  input  logic [NB_REG-1:0]  i_addr_rb,
  input  logic [NB_REG-1:0]  i_addr_rw,
  input  logic [NB_DATA-1:0] i_data_rw,
  output logic [NB_DATA-1:0] o_data_ra,
  output logic [NB_DATA-1:0] o_data_rb
);

  localparam int unsigned N_REGS = 2 ** NB_REG;

  logic [NB_DATA-1:0] regs [N_REGS];
  logic               wr_en;

  // Bypass is suppressed during reset so both ports read zero while it is held
  assign wr_en = i_rw && i_reset;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (i_rw && (i_addr_rw != NB_REG'(REG_ZERO))) begin
      regs[i_addr_rw] <= i_data_rw;
    end
  end

  bank_register_read_port #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG)
  ) u_port_a (
    .regs   (regs),
    .addr   (i_addr_ra),
    .wr_en  (wr_en),
    .addr_w (i_addr_rw),
    .data_w (i_data_rw),
    .data   (o_data_ra)
  );

  bank_register_read_port #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG)
  ) u_port_b (
    .regs   (regs),
    .addr   (i_addr_rb),
    .wr_en  (wr_en),
    .addr_w (i_addr_rw),
    .data_w (i_data_rw),
    .data   (o_data_rb)
  );

endmodule

// File: tb/tb_bank_register.sv
// Self-checking bench for bank_register: directed literal checks plus a randomized run against an array model.
module tb_bank_register;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  aw;
  logic [31:0] dw;
  logic [31:0] qa;
  logic [31:0] qb;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 0;

  logic [31:0] model [32];

  bank_register dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_rw      (rw),
    .i_addr_ra (ra),
    .i_addr_rb (rb),
    .i_addr_rw (aw),
    .i_data_rw (dw),
    .o_data_ra (qa),
    .o_data_rb (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the architectural rules
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (rw && (a == aw)) return dw;
    return model[a];
  endfunction

  // Model state: cleared on reset, written on clock when enabled and not r0
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (rst_n && rw && (aw != 5'd0)) model[aw] = dw;
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cyc_ra", qa, exp_read(ra));
      chk("cyc_rb", qb, exp_read(rb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst_n = 1'b0; rw = 1'b1; aw = 5'd21; dw = 32'd15; ra = 5'd21; rb = 5'd23;
    #2;
    run_chk = 1;
    repeat (3) step();
    chk("rst_ra", qa, 32'd0);
    chk("rst_rb", qb, 32'd0);

    rw = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_nowrite", qa, 32'd0);

    // Basic write/read
    rw = 1'b1; aw = 5'd21; dw = 32'd15;
    #1;
    chk("byp_first", qa, 32'd15);
    step();
    rw = 1'b0;
    #1;
    chk("wr21", qa, 32'd15);
    rw = 1'b1; aw = 5'd23; dw = 32'd20;
    step();
    aw = 5'd3; dw = 32'd25;
    step();
    aw = 5'd7; dw = 32'd30;
    step();
    rw = 1'b0;
    #1;
    chk("wr_ra15", qa, 32'd15);
    chk("wr_rb20", qb, 32'd20);

    // Write disable
    aw = 5'd23; dw = 32'd35;
    repeat (3) step();
    chk("wdis_rb", qb, 32'd20);
    rw = 1'b1; dw = 32'd88;
    step();
    rw = 1'b0;
    #1;
    chk("wen_rb88", qb, 32'd88);

    // Bypass on both ports
    ra = 5'd5; rb = 5'd5; rw = 1'b1; aw = 5'd5; dw = 32'hDEADBEEF;
    #1;
    chk("byp_pre_a", qa, 32'hDEADBEEF);
    chk("byp_pre_b", qb, 32'hDEADBEEF);
    step();
    chk("byp_post_a", qa, 32'hDEADBEEF);
    chk("byp_post_b", qb, 32'hDEADBEEF);
    rw = 1'b0;
    #1;
    chk("byp_hold", qa, 32'hDEADBEEF);

    // Register 0
    rw = 1'b1; aw = 5'd0; dw = 32'hFFFFFFFF; ra = 5'd0;
    #1;
    chk("r0_pre", qa, 32'd0);
    step();
    chk("r0_post", qa, 32'd0);
    rw = 1'b0;

    // Async reset between edges
    ra = 5'd21; rb = 5'd23;
    #1;
    chk("pre_rst_a", qa, 32'd15);
    chk("pre_rst_b", qb, 32'd88);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_a", qa, 32'd0);
    chk("arst_b", qb, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      ra = 5'(i); rb = 5'(31 - i);
      #1;
      chk("clr_a", qa, 32'd0);
      chk("clr_b", qb, 32'd0);
    end

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(99) != 0);
      rw    = ($urandom_range(2) != 0);
      ra    = 5'($urandom_range(31));
      rb    = ($urandom_range(4) == 0) ? ra : 5'($urandom_range(31));
      case ($urandom_range(5))
        0: aw = ra;
        1: aw = rb;
        2: aw = 5'd0;
        default: aw = 5'($urandom_range(31));
      endcase
      dw = $urandom();
      #2;
      chk("rnd_a", qa, exp_read(ra));
      chk("rnd_b", qb, exp_read(rb));
    end

    step();
    run_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
